// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between N_REQ byte producers
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DW           = 8,
    parameter int BUSY_TIMEOUT = 16,
    localparam int GW          = $clog2(N_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ*DW-1:0] i_req_data,
    output logic [N_REQ-1:0]    o_req_ready,
    output logic [DW-1:0]       o_tx_data,
    output logic                o_tx_wr,
    input  logic                i_tx_busy,
    output logic [GW-1:0]       o_grant_id,
    output logic                o_active,
    output logic                o_timeout_err
);

    localparam int CW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state;
    state_t          next_state;
    logic [GW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [GW-1:0]   win;
    logic [DW-1:0]   win_data;
    logic            grant_ok;
    logic            timeout_hit;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_g;
        found    = 1'b0;
        win      = '0;
        win_data = '0;
        idx      = 0;
        idx_g    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx   = (int'(last) + i) % N_REQ;
            idx_g = GW'(idx);
            if (!found && i_req_valid[idx_g]) begin
                found = 1'b1;
                win   = idx_g;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (win == GW'(k)) begin
                win_data = i_req_data[k*DW +: DW];
            end
        end
    end

    assign grant_ok    = (state == IDLE) && !i_tx_busy && found;
    assign timeout_hit = (state == WAIT_BUSY) && !i_tx_busy && (cnt == CW'(BUSY_TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx_data  <= '0;
            o_grant_id <= '0;
            last       <= GW'(N_REQ - 1);
            cnt        <= '0;
        end else begin
            if (grant_ok) begin
                o_tx_data  <= win_data;
                o_grant_id <= win;
                last       <= win;
            end
            if (state == WRITE) begin
                cnt <= '0;
            end else if (state == WAIT_BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (grant_ok) next_state = WRITE;
            WRITE:     next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                // A busy rise on the expiry edge still counts as acknowledged.
                if (i_tx_busy) begin
                    next_state = WAIT_DONE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            WAIT_DONE: if (!i_tx_busy) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        o_tx_wr       = (state == WRITE);
        o_active      = (state != IDLE);
        o_timeout_err = timeout_hit;
        o_req_ready   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            o_req_ready[k] = (state == WRITE) && (o_grant_id == GW'(k));
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_wr;
    logic            tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            active;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;
    int stray;
    logic act_fall;
    int last_m;

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .BUSY_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_wr(tx_wr), .i_tx_busy(tx_busy),
        .o_grant_id(grant_id), .o_active(active), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        tx_busy = 1'b0;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Plays a transmitter: busy rises a cycles after the strobe and stays high l cycles.
    task automatic frame_busy(input int a, input int l, input int drop);
        stray = 0;
        act_fall = 1'b0;
        for (int c = 1; c <= a + l; c++) begin
            step();
            tx_busy = (c >= a && c < a + l);
            if (c == 1 && drop >= 0) req_valid[drop] = 1'b0;
            #1;
            if (tx_wr || req_ready != '0 || timeout_err) stray++;
            if (c == a + l) act_fall = active;
        end
        step();
        tx_busy = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", tx_wr); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h want 0", req_ready); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        checks++; if ({active, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_active_err got %b want 00", {active, timeout_err}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_data[1*DW +: DW] = 8'h5A;
        req_valid = 4'b0010;
        step();
        checks++; if (tx_wr !== 1'b1) begin errors++; $display("FAIL single_wr got %0b want 1", tx_wr); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b want 0010", req_ready); end
        checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL single_data got %h want 5a", tx_data); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL single_grant got %0d want 1", grant_id); end
        frame_busy(1, 10, 1);
        checks++; if (stray !== 0) begin errors++; $display("FAIL single_stray got %0d want 0", stray); end
        checks++; if (act_fall !== 1'b1) begin errors++; $display("FAIL single_active_at_fall got %0b want 1", act_fall); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_active_after got %0b want 0", active); end
    endtask

    task automatic test_all_four();
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 8'(8'h10 + 8'h11 * k);
        req_valid = 4'b1111;
        for (int k = 0; k < N; k++) begin
            exp_d = 8'(8'h10 + 8'h11 * k);
            step();
            checks++; if (tx_wr !== 1'b1 || tx_data !== exp_d) begin errors++; $display("FAIL all4_strobe%0d got wr=%0b data=%h want wr=1 data=%h", k, tx_wr, tx_data, exp_d); end
            checks++; if (req_ready !== 4'(1 << k) || grant_id !== 2'(k)) begin errors++; $display("FAIL all4_ready%0d got %b/%0d want %b/%0d", k, req_ready, grant_id, 4'(1 << k), k); end
            frame_busy(1, 2, k);
            checks++; if (stray !== 0 || active !== 1'b0) begin errors++; $display("FAIL all4_frame%0d got stray=%0d active=%0b want 0/0", k, stray, active); end
        end
    endtask

    task automatic test_alternate();
        int exp_g;
        apply_reset();
        req_data[0*DW +: DW] = 8'hA0;
        req_data[2*DW +: DW] = 8'hC2;
        req_valid = 4'b0101;
        for (int f = 0; f < 4; f++) begin
            exp_g = (f % 2 == 0) ? 0 : 2;
            step();
            checks++; if (tx_wr !== 1'b1 || grant_id !== 2'(exp_g)) begin errors++; $display("FAIL alt_grant%0d got wr=%0b grant=%0d want 1/%0d", f, tx_wr, grant_id, exp_g); end
            checks++; if (tx_data !== ((exp_g == 0) ? 8'hA0 : 8'hC2)) begin errors++; $display("FAIL alt_data%0d got %h", f, tx_data); end
            frame_busy(2, 1, -1);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_timeout();
        req_data[1*DW +: DW] = 8'h77;
        req_valid = 4'b0010;
        step();
        checks++; if (tx_wr !== 1'b1) begin errors++; $display("FAIL to_wr got %0b want 1", tx_wr); end
        stray = 0;
        for (int c = 1; c < TO; c++) begin
            step();
            if (c == 1) req_valid = '0;
            if (timeout_err !== 1'b0 || active !== 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL to_early got %0d bad cycles want 0", stray); end
        step();
        checks++; if (timeout_err !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL to_pulse got err=%0b active=%0b want 1/1", timeout_err, active); end
        step();
        checks++; if (timeout_err !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL to_idle got err=%0b active=%0b want 0/0", timeout_err, active); end
        req_data[2*DW +: DW] = 8'h3C;
        req_valid = 4'b0100;
        step();
        checks++; if (tx_wr !== 1'b1 || grant_id !== 2'd2 || tx_data !== 8'h3C) begin errors++; $display("FAIL to_next got wr=%0b g=%0d d=%h want 1/2/3c", tx_wr, grant_id, tx_data); end
        // Busy rising on the expiry cycle must be taken as the acknowledge.
        for (int c = 1; c < TO; c++) begin
            step();
            if (c == 1) req_valid = '0;
        end
        step();
        tx_busy = 1'b1;
        #1;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_busy_wins got err=%0b want 0", timeout_err); end
        step();
        tx_busy = 1'b0;
        #1;
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL to_wait_done got active=%0b want 1", active); end
        step();
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL to_back_idle got active=%0b want 0", active); end
    endtask

    task automatic test_busy_hold();
        tx_busy = 1'b1;
        req_data[3*DW +: DW] = 8'hE3;
        req_valid = 4'b1000;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (tx_wr || req_ready != '0 || active) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL hold_no_grant got %0d bad cycles want 0", stray); end
        tx_busy = 1'b0;
        step();
        checks++; if (tx_wr !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'hE3 || req_ready !== 4'b1000) begin errors++; $display("FAIL hold_grant got wr=%0b g=%0d d=%h r=%b want 1/3/e3/1000", tx_wr, grant_id, tx_data, req_ready); end
        frame_busy(1, 3, 3);
    endtask

    task automatic test_reset_mid();
        req_data[1*DW +: DW] = 8'h11;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        tx_busy = 1'b1;
        step();
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_pre active got %0b want 1", active); end
        rst = 1'b1;
        #1;
        checks++; if ({tx_wr, req_ready, tx_data, grant_id, active, timeout_err} !== '0) begin errors++; $display("FAIL mid_reset_outputs got wr=%0b r=%b d=%h g=%0d a=%0b e=%0b want all 0", tx_wr, req_ready, tx_data, grant_id, active, timeout_err); end
        step();
        rst = 1'b0;
        req_data[0*DW +: DW] = 8'h0F;
        req_data[3*DW +: DW] = 8'hF3;
        req_valid = 4'b1001;
        step();
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL mid_busy_block got wr=%0b want 0", tx_wr); end
        tx_busy = 1'b0;
        step();
        checks++; if (tx_wr !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h0F) begin errors++; $display("FAIL mid_tie got wr=%0b g=%0d d=%h want 1/0/0f", tx_wr, grant_id, tx_data); end
        frame_busy(1, 2, 0);
        req_valid = '0;
        step();
    endtask

    task automatic test_random();
        int g;
        int a;
        int l;
        logic [DW-1:0] pd [N];
        apply_reset();
        last_m = N - 1;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 1) == 1) begin
                    pd[k] = 8'($urandom);
                    req_data[k*DW +: DW] = pd[k];
                    req_valid[k] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                g = $urandom_range(0, N - 1);
                pd[g] = 8'($urandom);
                req_data[g*DW +: DW] = pd[g];
                req_valid[g] = 1'b1;
            end
            #1;
            g = rr_pick(last_m, req_valid);
            step();
            checks++; if (tx_wr !== 1'b1 || req_ready !== 4'(1 << g) || grant_id !== 2'(g)) begin errors++; $display("FAIL rand%0d_grant got wr=%0b r=%b g=%0d want 1/%b/%0d", it, tx_wr, req_ready, grant_id, 4'(1 << g), g); end
            checks++; if (tx_data !== pd[g]) begin errors++; $display("FAIL rand%0d_data got %h want %h", it, tx_data, pd[g]); end
            last_m = g;
            a = $urandom_range(1, 4);
            l = $urandom_range(1, 6);
            frame_busy(a, l, g);
            checks++; if (stray !== 0 || act_fall !== 1'b1 || active !== 1'b0 || tx_data !== pd[g]) begin errors++; $display("FAIL rand%0d_frame got stray=%0d fall=%0b active=%0b d=%h want 0/1/0/%h", it, stray, act_fall, active, tx_data, pd[g]); end
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N_REQ byte producers using round-robin arbitration.
- Drives the transmitter's data bus and a one-cycle write strobe, then tracks its busy flag to frame completion.
- Sits between the application-side requesters and uart_tx, on the same (divided) clock that drives uart_tx.
- Flags a transmitter that never acknowledges a write.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width per byte.
- BUSY_TIMEOUT, 16, max cycles to wait for i_tx_busy to rise after a write strobe (>=2).
- GW, $clog2(N_REQ), grant index width (derived, not overridable).

Ports:
- i_clk  in  1  block clock, same clock as uart_tx.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  N_REQ  bit k = requester k has a byte pending; held until its ready bit pulses.
- i_req_data  in  N_REQ*DW  requester k's byte on bits [k*DW +: DW]; stable while valid.
- o_req_ready  out  N_REQ  one-cycle pulse; the byte of requester k is accepted.
- o_tx_data  out  DW  byte to transmitter; held from the write strobe until return to IDLE.
- o_tx_wr  out  1  one-cycle write strobe to transmitter.
- i_tx_busy  in  1  transmitter busy (high while a frame is shifting out).
- o_grant_id  out  GW  index of the requester most recently granted.
- o_active  out  1  high in every state except IDLE.
- o_timeout_err  out  1  one-cycle pulse when BUSY_TIMEOUT expires.

Behaviour:
- Reset values (async, i_rst=1): all outputs 0; state IDLE; RR pointer last=N_REQ-1 (requester 0 has top priority first); timeout counter 0.
- States: IDLE, WRITE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - On a clock edge where i_tx_busy=0 and any i_req_valid bit is set, select winner g, the first set bit searching last+1, last+2, ... modulo N_REQ.
  - At that edge, register o_tx_data = data of g, o_grant_id = g, last = g; go to WRITE.
  - If i_tx_busy=1, stay in IDLE and grant nothing, even with valids pending.
- WRITE (exactly 1 cycle):
  - o_tx_wr=1, o_req_ready[g]=1, all other ready bits 0.
  - Clear the timeout counter; go to WAIT_BUSY.
  - Latency: valid sampled at edge n, so strobe and ready are high during cycle n+1.
- WAIT_BUSY:
  - Increment the counter each cycle.
  - i_tx_busy=1: go to WAIT_DONE.
  - Else, counter reaching BUSY_TIMEOUT-1: pulse o_timeout_err for 1 cycle, go to IDLE; the byte is dropped, not retried.
  - If busy rises on the same edge the counter expires, busy wins: no error.
- WAIT_DONE: wait for i_tx_busy=0, then go to IDLE. No timeout in this state (frame length depends on baud).
- Requesters:
  - Valids are sampled only in IDLE. A valid that drops before a grant is simply not served.
  - Valids changing in other states have no effect.
  - A requester may re-assert valid in the cycle after its ready pulse; it then waits its RR turn.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 other frames.
- Minimum spacing between successive o_tx_wr strobes: 4 cycles (WRITE, WAIT_BUSY >=1, WAIT_DONE >=1, IDLE).
- o_tx_data is unchanged from WRITE until the next grant.
- Reset asserted mid-operation: immediate return to reset values. The in-flight frame is not tracked; the IDLE busy check prevents a new strobe while the transmitter still shifts.

Test Plan:
- Single request: req1 valid, data 0x5A, busy pulses high 10 cycles starting 1 cycle after strobe → ready[1] and o_tx_wr high same cycle (1 cycle after sample), o_tx_data=0x5A, o_grant_id=1, o_active falls 1 cycle after busy falls.
- All 4 valid at once after reset (bytes 0x10,0x21,0x32,0x43) → strobes carry 0x10,0x21,0x32,0x43 in that order; one ready pulse each.
- Req0 held valid continuously plus req2 valid → grants alternate 0,2,0,2; req2 never starved.
- Busy never rises after a strobe, BUSY_TIMEOUT=16 → o_timeout_err pulses exactly 16 cycles after WRITE, FSM back in IDLE; next request is served normally.
- i_tx_busy held high while req3 valid in IDLE → no strobe and no ready; after busy drops, grant occurs on the next edge.
- Assert i_rst during WAIT_DONE → all outputs 0 immediately; after release, requester 0 wins a tie against requester 3.
